// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, issues word fetches to instruction memory (at most one outstanding),
// registers returned words into IF/ID, absorbs one word in a skid buffer while decode
// stalls, and flushes on execute-stage redirects.
//
// Ports:
//   clk, rst                  core clock; asynchronous active-high reset
//   imem_req, imem_addr       fetch request (combinational, always accepted)
//   imem_rvalid, imem_rdata   in-order read response, one per request
//   stall                     decode cannot accept this cycle
//   redirect, redirect_pc     taken branch / jump target from execute
//   if_id_valid, if_id_pc,
//   if_id_instr               IF/ID register contents (instr is NOP when invalid)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next4;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        accept;
    logic        unused_bits;

    // Low target bits are architecturally ignored.
    assign unused_bits = ^redirect_pc[1:0];

    assign accept   = !stall || !if_id_valid;
    assign pc_next4 = pc + 32'd4;

    // Request is combinational so a returning word can chain the next fetch in the
    // same cycle, giving one instruction per cycle with single-cycle memory.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        if (!rst && !redirect) begin
            unique case (state)
                ST_IDLE: imem_req = 1'b1;
                ST_WAIT: begin
                    if (imem_rvalid && accept) begin
                        imem_req  = 1'b1;
                        imem_addr = pc_next4;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fetch FSM, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC_ALIGNED;
            skid_pc     <= 32'd0;
            skid_instr  <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'd0;
            if_id_instr <= NOP_INSTR;
        end else if (redirect) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            // A still-outstanding response must be swallowed before refetching.
            if ((state == ST_WAIT && !imem_rvalid) || state == ST_DISCARD)
                state <= ST_DISCARD;
            else
                state <= ST_IDLE;
        end else begin
            // Default when no new word lands: bubble if decode is taking, else hold.
            if (accept) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end
            unique case (state)
                ST_IDLE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        pc <= pc_next4;
                        if (accept) begin
                            if_id_valid <= 1'b1;
                            if_id_pc    <= pc;
                            if_id_instr <= imem_rdata;
                        end else begin
                            skid_pc    <= pc;
                            skid_instr <= imem_rdata;
                            state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_pc    <= skid_pc;
                        if_id_instr <= skid_instr;
                        state       <= ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (imem_rvalid)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test of fetch_stage with a latency-programmable memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    int total;
    int bad;
    int lat;

    logic [31:0] pend_addr[$];
    int          pend_cnt[$];

    fetch_stage #(
        .RESET_PC (32'h0000_0100),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid),
        .if_id_pc   (if_id_pc),
        .if_id_instr(if_id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        if (a == 32'h0000_0104) return 32'h00A0_0113;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Capture this cycle's request, advance one clock, then drive memory's response.
    task automatic step();
        if (imem_req) begin
            pend_addr.push_back(imem_addr);
            pend_cnt.push_back(lat);
        end
        @(posedge clk);
        #1;
        foreach (pend_cnt[i]) pend_cnt[i] = pend_cnt[i] - 1;
        if (pend_cnt.size() > 0 && pend_cnt[0] <= 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_cnt.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        lat = 1;
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'd0;

        // Reset takes effect without a clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_pc", if_id_pc, 32'd0);
        check("rst_instr", if_id_instr, NOP);
        check("rst_req", 32'(imem_req), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h100);

        // Back-to-back fetch with single-cycle memory.
        step(); #1;
        check("c1_req", 32'(imem_req), 32'd1);
        check("c1_addr", imem_addr, 32'h104);
        check("c1_valid", 32'(if_id_valid), 32'd0);
        step(); #1;
        check("c2_valid", 32'(if_id_valid), 32'd1);
        check("c2_pc", if_id_pc, 32'h100);
        check("c2_instr", if_id_instr, 32'h0050_0093);
        check("c2_addr", imem_addr, 32'h108);
        step();
        stall = 1'b1;
        #1;
        check("c3_pc", if_id_pc, 32'h104);
        check("c3_instr", if_id_instr, 32'h00A0_0113);
        check("c3_req_stalled", 32'(imem_req), 32'd0);

        // Skid holds 0x108 while IF/ID keeps 0x104.
        step(); #1;
        check("c4_req", 32'(imem_req), 32'd0);
        check("c4_pc", if_id_pc, 32'h104);
        check("c4_valid", 32'(if_id_valid), 32'd1);
        step();
        stall = 1'b0;
        #1;
        check("c5_req", 32'(imem_req), 32'd0);
        check("c5_pc", if_id_pc, 32'h104);
        step(); #1;
        check("c6_pc", if_id_pc, 32'h108);
        check("c6_instr", if_id_instr, mem_word(32'h108));
        check("c6_addr", imem_addr, 32'h10C);
        check("c6_req", 32'(imem_req), 32'd1);
        step(); #1;
        check("c7_valid", 32'(if_id_valid), 32'd0);
        check("c7_instr", if_id_instr, NOP);
        check("c7_addr", imem_addr, 32'h110);
        step(); #1;
        check("c8_pc", if_id_pc, 32'h10C);
        check("c8_instr", if_id_instr, mem_word(32'h10C));

        // Three-cycle memory, redirect while a response is outstanding.
        lat = 3;
        step(); #1;
        check("c9_pc", if_id_pc, 32'h110);
        check("c9_req", 32'(imem_req), 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        #1;
        check("c10_valid", 32'(if_id_valid), 32'd0);
        check("c10_instr", if_id_instr, NOP);
        check("c10_req", 32'(imem_req), 32'd0);
        step(); #1;
        check("c11_rvalid_seen", 32'(imem_rvalid), 32'd1);
        check("c11_req", 32'(imem_req), 32'd0);
        check("c11_valid", 32'(if_id_valid), 32'd0);
        lat = 1;
        step(); #1;
        check("c12_req", 32'(imem_req), 32'd1);
        check("c12_addr", imem_addr, 32'h200);
        check("c12_valid", 32'(if_id_valid), 32'd0);
        step(); #1;
        check("c13_addr", imem_addr, 32'h204);
        step();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        check("c14_pc", if_id_pc, 32'h200);
        check("c14_instr", if_id_instr, mem_word(32'h200));
        check("c14_req", 32'(imem_req), 32'd0);

        // PC wraps modulo 2^32.
        step();
        redirect = 1'b0;
        #1;
        check("c15_valid", 32'(if_id_valid), 32'd0);
        check("c15_addr", imem_addr, 32'hFFFF_FFFC);
        check("c15_req", 32'(imem_req), 32'd1);
        step(); #1;
        check("c16_addr", imem_addr, 32'h0000_0000);
        step();
        redirect = 1'b1;
        redirect_pc = 32'h203;
        #1;
        check("c17_pc", if_id_pc, 32'hFFFF_FFFC);
        check("c17_instr", if_id_instr, mem_word(32'hFFFF_FFFC));
        check("c17_req", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0;
        #1;
        check("c18_addr_aligned", imem_addr, 32'h200);
        check("c18_req", 32'(imem_req), 32'd1);

        // Reset mid-WAIT; the late response must be ignored.
        lat = 3;
        step();
        rst = 1'b1;
        #1;
        check("c19_req", 32'(imem_req), 32'd0);
        check("c19_pc", if_id_pc, 32'd0);
        check("c19_instr", if_id_instr, NOP);
        check("c19_valid", 32'(if_id_valid), 32'd0);
        step();
        step();
        rst = 1'b0;
        lat = 1;
        #1;
        check("c21_late_rvalid", 32'(imem_rvalid), 32'd1);
        check("c21_addr", imem_addr, 32'h100);
        check("c21_req", 32'(imem_req), 32'd1);
        step(); #1;
        check("c22_valid", 32'(if_id_valid), 32'd0);
        check("c22_addr", imem_addr, 32'h104);
        step(); #1;
        check("c23_valid", 32'(if_id_valid), 32'd1);
        check("c23_pc", if_id_pc, 32'h100);
        check("c23_instr", if_id_instr, 32'h0050_0093);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
